// File: rtl/matmul_ctrl_regs_if.sv
// Host register bus for the matmul control/status block.
// Latency: reads return one cycle after the strobe; writes take effect at the sampling edge.
// Backpressure: none; the slave accepts one read and one write per cycle.
// Signals: wr_en_i/rd_en_i strobes, addr_i word address, wdata_i write data,
//          rdata_o registered read data, rvalid_o one-cycle read-valid pulse.
interface matmul_ctrl_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en_i;
  logic                  rd_en_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rvalid_o;

  // Host side drives strobes/address/data, register block returns read data.
  modport master (
    output wr_en_i, rd_en_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o
  );

  modport slave (
    input  wr_en_i, rd_en_i, addr_i, wdata_i,
    output rdata_o, rvalid_o
  );
endinterface

// File: rtl/matmul_ctrl_regs.sv
// Control/status registers and start/busy/done sequencer for the matmul datapath.
// Latency: writes visible after the sampling edge; reads, start_o and irq_o are registered (1 cycle).
// Backpressure: none; CONTROL writes during BUSY are dropped and flagged in STATUS.err_wr_busy.
// Ports: clk_i/rst_i (sync, active-high), bus (slave register bus), done_i datapath completion,
//        start_o one-cycle start pulse, busy_o, cfg_o live CONTROL (bit0 = busy), irq_o level interrupt.
module matmul_ctrl_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DIM_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  matmul_ctrl_regs_if.slave     bus,
  input  logic                  done_i,
  output logic                  start_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] cfg_o,
  output logic                  irq_o
);

  // CONTROL holds fields in bits [CTRL_W-1:1]; bit0 is never stored, it reads as busy.
  localparam int CTRL_W = 10 + 3 * DIM_W;
  localparam logic [DATA_WIDTH-1:0] CTRL_MASK = DATA_WIDTH'((64'd1 << CTRL_W) - 64'd2);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IRQE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(2);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  done_q, done_d;
  logic                  err_wr_busy_q, err_wr_busy_d;
  logic                  err_addr_q, err_addr_d;
  logic                  done_ie_q, done_ie_d;
  logic                  err_ie_q, err_ie_d;
  logic                  start_q, start_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic busy;
  logic wr_ctrl, wr_stat, wr_irqe, bad_addr;

  assign busy     = (state_q == ST_BUSY);
  assign wr_ctrl  = bus.wr_en_i && (bus.addr_i == ADDR_CTRL);
  assign wr_stat  = bus.wr_en_i && (bus.addr_i == ADDR_STAT);
  assign wr_irqe  = bus.wr_en_i && (bus.addr_i == ADDR_IRQE);
  assign bad_addr = (bus.addr_i > ADDR_LAST);

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    done_d        = done_q;
    err_wr_busy_d = err_wr_busy_q;
    err_addr_d    = err_addr_q;
    done_ie_d     = done_ie_q;
    err_ie_d      = err_ie_q;
    start_d       = 1'b0;
    rvalid_d      = bus.rd_en_i;
    rdata_d       = rdata_q;

    // Read path uses pre-edge register values, so a same-edge write is not visible.
    if (bus.rd_en_i) begin
      case (bus.addr_i)
        ADDR_CTRL: rdata_d = {ctrl_q[DATA_WIDTH-1:1], busy};
        ADDR_STAT: rdata_d = DATA_WIDTH'({err_addr_q, err_wr_busy_q, done_q, busy});
        ADDR_IRQE: rdata_d = DATA_WIDTH'({err_ie_q, done_ie_q});
        default:   rdata_d = '0;
      endcase
    end

    // W1C clears come first so any hardware set below in the same cycle wins.
    if (wr_stat) begin
      if (bus.wdata_i[1]) done_d        = 1'b0;
      if (bus.wdata_i[2]) err_wr_busy_d = 1'b0;
      if (bus.wdata_i[3]) err_addr_d    = 1'b0;
    end

    if (wr_irqe) begin
      done_ie_d = bus.wdata_i[0];
      err_ie_d  = bus.wdata_i[1];
    end

    case (state_q)
      ST_IDLE: begin
        // done_i is ignored here; only a CONTROL write matters.
        if (wr_ctrl) begin
          ctrl_d = bus.wdata_i & CTRL_MASK;
          if (bus.wdata_i[0]) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (wr_ctrl) err_wr_busy_d = 1'b1;
        if (done_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((bus.wr_en_i || bus.rd_en_i) && bad_addr) err_addr_d = 1'b1;

    // Interrupt is built from the registered flags, so it trails them by one edge.
    irq_d = (done_q & done_ie_q) | ((err_wr_busy_q | err_addr_q) & err_ie_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      done_q        <= 1'b0;
      err_wr_busy_q <= 1'b0;
      err_addr_q    <= 1'b0;
      done_ie_q     <= 1'b0;
      err_ie_q      <= 1'b0;
      start_q       <= 1'b0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      done_q        <= done_d;
      err_wr_busy_q <= err_wr_busy_d;
      err_addr_q    <= err_addr_d;
      done_ie_q     <= done_ie_d;
      err_ie_q      <= err_ie_d;
      start_q       <= start_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign start_o      = start_q;
  assign busy_o       = busy;
  assign cfg_o        = {ctrl_q[DATA_WIDTH-1:1], busy};
  assign irq_o        = irq_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;

endmodule
